// File: rtl/crc_pkg.sv
// Shared CRC constants and bit-level helpers for the streaming CRC engine.
// Helpers work on 32-bit containers; callers pass the live CRC width.
package crc_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFF_FFFF;
    localparam int          MAX_LANES     = 8;

    function automatic logic [31:0] width_mask(input int w);
        if (w >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [7:0] lane_mask(input int n);
        if (n >= MAX_LANES) return 8'hFF;
        return (8'd1 << n) - 8'd1;
    endfunction

    // Eight serial LFSR shifts of one byte; refin selects LSB-first bit order.
    function automatic logic [31:0] crc_byte_step(input logic [31:0] state,
                                                  input logic [7:0]  data,
                                                  input logic [31:0] poly,
                                                  input logic        refin,
                                                  input int          w);
        logic [31:0] mask;
        logic [31:0] s;
        logic        in_bit;
        logic        fb;
        mask = width_mask(w);
        s    = state & mask;
        for (int i = 0; i < 8; i++) begin
            in_bit = refin ? (((data >> i) & 8'h01) != 8'h00)
                           : (((data << i) & 8'h80) != 8'h00);
            fb     = (((s >> (w - 1)) & 32'd1) != 32'd0) ^ in_bit;
            s      = (s << 1) & mask;
            if (fb) s = s ^ (poly & mask);
        end
        return s;
    endfunction

    function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w && ((v >> i) & 32'd1) != 32'd0) r = r | (32'd1 << (w - 1 - i));
        end
        return r;
    endfunction

    // Legal end-of-packet keep: non-empty and contiguous from lane 0.
    function automatic logic keep_valid(input logic [7:0] keep, input int n);
        logic [7:0] k;
        k = keep & lane_mask(n);
        return (k != 8'h00) && ((k & (k + 8'h01)) == 8'h00);
    endfunction

    // Number of kept lanes before the first cleared keep bit.
    function automatic int keep_prefix_len(input logic [7:0] keep, input int n);
        int   c;
        logic run;
        c   = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (run && i < n && ((keep >> i) & 8'h01) != 8'h00) c++;
            else run = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Input word stream and output CRC handshake of the streaming CRC engine.
interface crc_stream_engine_if #(
    parameter int DATA_W = 32,
    parameter int CRC_W  = 32
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_W-1:0]     s_data;
    logic [DATA_W/8-1:0]   s_keep;
    logic                  s_eop;
    logic                  m_valid;
    logic                  m_ready;
    logic [CRC_W-1:0]      m_crc;

    modport master (
        output s_valid, s_data, s_keep, s_eop, m_ready,
        input  s_ready, m_valid, m_crc
    );

    modport slave (
        input  s_valid, s_data, s_keep, s_eop, m_ready,
        output s_ready, m_valid, m_crc
    );
endinterface

// File: rtl/crc_lane_fold.sv
// Combinational fold of the first `count` byte lanes of a word into a CRC state.
// Lane 0 is folded first; each prefix of the byte chain is a mux candidate.
module crc_lane_fold
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 32,
    parameter int               DATA_W = 32,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC32_POLY),
    parameter bit               REFIN  = 1'b1,
    localparam int              LANES  = DATA_W / 8,
    localparam int              CNT_W  = $clog2(LANES + 1)
) (
    input  logic [CRC_W-1:0]  state,
    input  logic [DATA_W-1:0] data,
    input  logic [CNT_W-1:0]  count,
    output logic [CRC_W-1:0]  folded
);

    logic [CRC_W-1:0] chain [LANES+1];

    assign chain[0] = state;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign chain[i+1] = CRC_W'(crc_byte_step(32'(chain[i]), data[8*i +: 8],
                                                 32'(POLY), REFIN, CRC_W));
    end

    always_comb begin
        folded = state;
        for (int i = 0; i <= LANES; i++) begin
            if (count == CNT_W'(i)) folded = chain[i];
        end
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: owns the running state, folds keep-masked words and
// presents one finalised CRC per packet on a held output handshake.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 32,
    parameter int               DATA_W  = 32,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC32_POLY),
    parameter logic [CRC_W-1:0] INIT    = CRC_W'(CRC32_INIT),
    parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(CRC32_XOR_OUT),
    parameter bit               REFIN   = 1'b1,
    parameter bit               REFOUT  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    crc_stream_engine_if.slave  bus,
    output logic                err,
    output logic                busy
);

    localparam int LANES = DATA_W / 8;
    localparam int CNT_W = $clog2(LANES + 1);

    logic [CRC_W-1:0] state_p1;
    logic [CRC_W-1:0] crc_p1;
    logic             vld_p1;
    logic             err_p1;
    logic             busy_p1;

    logic             xfer;
    logic             keep_bad;
    logic [CNT_W-1:0] fold_cnt;
    logic [CRC_W-1:0] folded;

    function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] s);
        logic [CRC_W-1:0] r;
        r = REFOUT ? CRC_W'(bit_reverse(32'(s), CRC_W)) : s;
        return r ^ XOR_OUT;
    endfunction

    // A held result blocks input so it can never be overwritten unseen.
    assign bus.s_ready = !vld_p1 || bus.m_ready;
    assign xfer        = bus.s_valid && bus.s_ready;
    assign keep_bad    = bus.s_eop ? !keep_valid(8'(bus.s_keep), LANES) : !(&bus.s_keep);
    assign fold_cnt    = bus.s_eop ? CNT_W'(keep_prefix_len(8'(bus.s_keep), LANES))
                                   : CNT_W'(LANES);

    crc_lane_fold #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY),
        .REFIN  (REFIN)
    ) u_fold (
        .state  (state_p1),
        .data   (bus.s_data),
        .count  (fold_cnt),
        .folded (folded)
    );

    // Stage p1: running state, held result and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= INIT;
            crc_p1   <= '0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            busy_p1  <= 1'b0;
        end else begin
            err_p1 <= xfer && keep_bad;
            if (vld_p1 && bus.m_ready) vld_p1 <= 1'b0;
            if (xfer) begin
                if (bus.s_eop) begin
                    state_p1 <= INIT;
                    crc_p1   <= finalize(folded);
                    vld_p1   <= 1'b1;
                    busy_p1  <= 1'b0;
                end else begin
                    state_p1 <= folded;
                    busy_p1  <= 1'b1;
                end
            end
        end
    end

    assign bus.m_valid = vld_p1;
    assign bus.m_crc   = crc_p1;
    assign err         = err_p1;
    assign busy        = busy_p1;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Randomised self-checking bench for crc_stream_engine against bytewise CRC models.
module tb_crc_stream_engine;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc_stream_engine_if #(.DATA_W(32), .CRC_W(32)) a_if ();
    crc_stream_engine_if #(.DATA_W(8),  .CRC_W(16)) b_if ();
    logic err_a, busy_a, err_b, busy_b;

    crc_stream_engine dut_a (
        .clk (clk), .rst (rst), .bus (a_if), .err (err_a), .busy (busy_a)
    );

    crc_stream_engine #(
        .CRC_W (16), .DATA_W (8), .POLY (16'h1021), .INIT (16'hFFFF),
        .XOR_OUT (16'h0000), .REFIN (1'b0), .REFOUT (1'b0)
    ) dut_b (
        .clk (clk), .rst (rst), .bus (b_if), .err (err_b), .busy (busy_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reflected CRC-32 (right-shifting, reversed polynomial).
    function automatic logic [31:0] model_crc32(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ 32'(b[i]);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c ^ 32'hFFFF_FFFF;
    endfunction

    // CRC-16/CCITT-FALSE, byte-at-top formulation.
    function automatic logic [15:0] model_crc16(input bq_t b);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            c = c ^ {b[i], 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic bq_t word_bytes(input logic [31:0] w, input int n);
        bq_t q;
        for (int j = 0; j < n; j++) q.push_back(8'(w >> (8 * j)));
        return q;
    endfunction

    logic [31:0] res_a [$];
    logic [15:0] res_b [$];
    int          err_cnt_a = 0;
    logic        rnd_ready = 1'b0;

    always @(negedge clk) begin
        if (a_if.m_valid && a_if.m_ready) res_a.push_back(a_if.m_crc);
        if (b_if.m_valid && b_if.m_ready) res_b.push_back(b_if.m_crc);
        if (err_a) err_cnt_a <= err_cnt_a + 1;
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            a_if.m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic [3:0] k, input logic e);
        int t;
        a_if.s_valid = 1'b1; a_if.s_data = d; a_if.s_keep = k; a_if.s_eop = e;
        t = 0;
        forever begin
            @(negedge clk);
            if (a_if.s_ready) break;
            t++;
            if (t > 200) begin check("a_s_ready_timeout", 32'd0, 32'd1); break; end
        end
        tick();
        a_if.s_valid = 1'b0; a_if.s_eop = 1'b0; a_if.s_keep = 4'hF;
    endtask

    task automatic send_b(input logic [7:0] d, input logic e);
        int t;
        b_if.s_valid = 1'b1; b_if.s_data = d; b_if.s_keep = 1'b1; b_if.s_eop = e;
        t = 0;
        forever begin
            @(negedge clk);
            if (b_if.s_ready) break;
            t++;
            if (t > 200) begin check("b_s_ready_timeout", 32'd0, 32'd1); break; end
        end
        tick();
        b_if.s_valid = 1'b0; b_if.s_eop = 1'b0;
    endtask

    task automatic pop_a(input string tag, output logic [31:0] v);
        int t;
        t = 0;
        while (res_a.size() == 0 && t < 200) begin tick(); t++; end
        if (res_a.size() == 0) begin check({tag, "_timeout"}, 32'd0, 32'd1); v = 'x; end
        else v = res_a.pop_front();
    endtask

    task automatic pop_b(input string tag, output logic [15:0] v);
        int t;
        t = 0;
        while (res_b.size() == 0 && t < 200) begin tick(); t++; end
        if (res_b.size() == 0) begin check({tag, "_timeout"}, 32'd0, 32'd1); v = 'x; end
        else v = res_b.pop_front();
    endtask

    // Unkept tail lanes carry junk so the bench notices if they are folded.
    task automatic send_pkt_a(input bq_t b);
        int n, nw, rem;
        logic [31:0] d;
        n = b.size();
        if (n == 0) begin
            send_a($urandom, 4'h0, 1'b1);
            return;
        end
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            rem = (n - 4 * w > 4) ? 4 : (n - 4 * w);
            d = $urandom;
            for (int j = 0; j < rem; j++) begin
                d = (d & ~(32'hFF << (8 * j))) | (32'(b[4 * w + j]) << (8 * j));
            end
            send_a(d, 4'((1 << rem) - 1), w == nw - 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t         s9, q;
        logic [31:0] v, d1, d2, exp1, exp2;
        logic [15:0] vb;
        logic [31:0] exp_q [$];
        int          exp_err, err_base, t, len;

        a_if.s_valid = 1'b0; a_if.s_data = '0; a_if.s_keep = 4'hF; a_if.s_eop = 1'b0;
        a_if.m_ready = 1'b1;
        b_if.s_valid = 1'b0; b_if.s_data = '0; b_if.s_keep = 1'b1; b_if.s_eop = 1'b0;
        b_if.m_ready = 1'b1;
        for (int i = 0; i < 9; i++) s9.push_back(8'h31 + 8'(i));

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 32'(a_if.m_valid), 32'd0);
        check("rst_m_crc",   a_if.m_crc,        32'd0);
        check("rst_err",     32'(err_a),        32'd0);
        check("rst_busy",    32'(busy_a),       32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_s_ready", 32'(a_if.s_ready), 32'd1);
        tick();

        // "123456789" with partial last word
        send_a(32'h3433_3231, 4'hF, 1'b0);
        check("busy_mid", 32'(busy_a), 32'd1);
        send_a(32'h3837_3635, 4'hF, 1'b0);
        send_a(32'h0000_0039, 4'h1, 1'b1);
        check("check_lat_valid", 32'(a_if.m_valid), 32'd1);
        check("check_crc",       a_if.m_crc,        32'hCBF4_3926);
        check("busy_after_eop",  32'(busy_a),       32'd0);
        pop_a("check_pop", v);
        check("check_model", v, model_crc32(s9));

        send_a(32'h0, 4'hF, 1'b1);
        pop_a("zero4", v);
        check("zero4_crc", v, 32'h2144_DF1C);
        send_a(32'h0, 4'h1, 1'b1);
        pop_a("zero1", v);
        check("zero1_crc", v, 32'hD202_EF8D);

        // Held result stalls input; release coincides with next eop
        d1 = $urandom; d2 = $urandom;
        exp1 = model_crc32(word_bytes(d1, 4));
        exp2 = model_crc32(word_bytes(d2, 4));
        a_if.m_ready = 1'b0;
        send_a(d1, 4'hF, 1'b1);
        check("stall_first", a_if.m_crc, exp1);
        a_if.s_valid = 1'b1; a_if.s_data = d2; a_if.s_keep = 4'hF; a_if.s_eop = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_s_ready", 32'(a_if.s_ready), 32'd0);
            check("stall_m_crc",   a_if.m_crc,        exp1);
            check("stall_m_valid", 32'(a_if.m_valid), 32'd1);
        end
        tick();
        a_if.m_ready = 1'b1;
        @(negedge clk);
        check("swap_s_ready", 32'(a_if.s_ready), 32'd1);
        tick();
        check("swap_m_valid", 32'(a_if.m_valid), 32'd1);
        check("swap_m_crc",   a_if.m_crc,        exp2);
        a_if.s_valid = 1'b0; a_if.s_eop = 1'b0;
        pop_a("swap_old", v);
        check("swap_old_crc", v, exp1);
        pop_a("swap_new", v);
        check("swap_new_crc", v, exp2);

        // Illegal keeps
        d1 = $urandom; d2 = $urandom;
        send_a(d1, 4'b0101, 1'b1);
        check("err_0101_pulse", 32'(err_a), 32'd1);
        check("err_0101_crc",   a_if.m_crc, model_crc32(word_bytes(d1, 1)));
        tick();
        check("err_0101_clear", 32'(err_a), 32'd0);
        pop_a("err_0101", v);

        send_a(d1, 4'b0011, 1'b0);
        check("err_mid_pulse", 32'(err_a), 32'd1);
        send_a(d2, 4'hF, 1'b1);
        check("err_mid_eop_ok", 32'(err_a), 32'd0);
        q = word_bytes(d1, 4);
        for (int j = 0; j < 4; j++) q.push_back(8'(d2 >> (8 * j)));
        pop_a("err_mid", v);
        check("err_mid_crc", v, model_crc32(q));

        send_a(d1, 4'hF, 1'b0);
        send_a(d2, 4'h0, 1'b1);
        check("keep0_err", 32'(err_a), 32'd1);
        pop_a("keep0", v);
        check("keep0_crc", v, model_crc32(word_bytes(d1, 4)));
        send_a(d2, 4'h0, 1'b1);
        pop_a("empty", v);
        check("empty_crc", v, model_crc32(word_bytes(d2, 0)));

        // Reset mid-packet
        send_a(32'h3433_3231, 4'hF, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_m_valid", 32'(a_if.m_valid), 32'd0);
        check("midrst_busy",    32'(busy_a),       32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_m_valid", 32'(a_if.m_valid), 32'd0);
        check("postrst_no_result", 32'(res_a.size()), 32'd0);
        tick();
        send_pkt_a(s9);
        pop_a("resend", v);
        check("resend_crc", v, 32'hCBF4_3926);

        // Random packets under random output backpressure
        err_base = err_cnt_a;
        exp_err  = 0;
        rnd_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            q = {};
            len = $urandom_range(0, 13);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            exp_q.push_back(model_crc32(q));
            if (len == 0) exp_err++;
            send_pkt_a(q);
        end
        rnd_ready = 1'b0;
        tick();
        a_if.m_ready = 1'b1;
        t = 0;
        while (res_a.size() < 40 && t < 2000) begin tick(); t++; end
        check("rand_count", 32'(res_a.size()), 32'd40);
        for (int i = 0; i < 40 && i < res_a.size(); i++) begin
            check($sformatf("rand_%0d", i), res_a[i], exp_q[i]);
        end
        check("rand_err_count", 32'(err_cnt_a - err_base), 32'(exp_err));
        res_a = {};

        // CRC-16/CCITT-FALSE instance with byte-wide input
        for (int i = 0; i < 9; i++) begin
            send_b(s9[i], i == 8);
            if (i == 0) check("b_busy_mid", 32'(busy_b), 32'd1);
        end
        check("b_lat_valid", 32'(b_if.m_valid), 32'd1);
        check("b_crc16", 32'(b_if.m_crc), 32'h0000_29B1);
        check("b_err", 32'(err_b), 32'd0);
        pop_b("b_check", vb);
        for (int p = 0; p < 4; p++) begin
            q = {};
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            for (int i = 0; i < len; i++) send_b(q[i], i == len - 1);
            pop_b("b_rand", vb);
            check($sformatf("b_rand_%0d", p), 32'(vb), 32'(model_crc16(q)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
